// File: rtl/fu_wb_fifo_pkg.sv
// Shared pipeline package: CDB result format and writeback-buffer sizing.
package fu_wb_fifo_pkg;

  localparam int ROB_ID_W      = 6;
  localparam int PREG_W        = 7;
  localparam int XLEN          = 32;
  localparam int WB_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    FU_ALU0 = 2'd0,
    FU_ALU1 = 2'd1,
    FU_MDU  = 2'd2,
    FU_LSU  = 2'd3
  } fu_id_t;

  typedef struct packed {
    logic [ROB_ID_W-1:0] rob_id;
    logic                r_valid;
    logic [PREG_W-1:0]   prd;
    logic [XLEN-1:0]     wdata;
    logic                exc_valid;
  } cdb_info_t;

endpackage

// File: rtl/handshake_if.sv
// Generic valid/ready channel with sender and receiver views.
interface handshake_if #(
  parameter int W = 1
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport sender   (output valid, output data, input  ready);
  modport receiver (input  valid, input  data, output ready);
endinterface

// File: rtl/fu_wb_fifo_chk.sv
// Simulation-only occupancy checks, attached to every fu_wb_fifo instance.
module fu_wb_fifo_chk #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input logic             clk,
  input logic             rst,
  input logic             push,
  input logic             pop,
  input logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);

  a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && count == FULL_C));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) !(pop && count == {CNT_W{1'b0}}));
  a_count_range:  assert property (@(posedge clk) disable iff (rst) count <= FULL_C);

endmodule

bind fu_wb_fifo fu_wb_fifo_chk #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_chk (
  .clk   (clk),
  .rst   (rst),
  .push  (push_s),
  .pop   (pop_s),
  .count (count_r)
);

// File: rtl/fu_wb_fifo.sv
// Per-FU writeback buffer feeding one CDB arbiter port; strict FIFO order,
// results without r_valid are acknowledged but not stored.
module fu_wb_fifo
  import fu_wb_fifo_pkg::*;
#(
  parameter int DEPTH = WB_FIFO_DEPTH,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [$bits(cdb_info_t)-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$bits(cdb_info_t)-1:0] out_data,
  output logic [CNT_W-1:0]          count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int DW    = $bits(cdb_info_t);
  localparam logic [CNT_W-1:0] FULL_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ZERO_C  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [PTR_W-1:0] PONE_C  = PTR_W'(1);

  handshake_if #(.W(DW)) in_if ();
  handshake_if #(.W(DW)) out_if ();

  cdb_info_t        mem_r [DEPTH];
  cdb_info_t        in_info_s;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_next_s;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             push_s;
  logic             pop_s;

  assign in_if.valid  = in_valid;
  assign in_if.data   = in_data;
  assign in_if.ready  = in_ready_r;
  assign in_ready     = in_if.ready;

  assign out_if.valid = out_valid_r;
  assign out_if.data  = mem_r[rd_ptr_r];
  assign out_if.ready = out_ready;
  assign out_valid    = out_if.valid;
  assign out_data     = out_if.data;

  assign count        = count_r;
  assign in_info_s    = cdb_info_t'(in_if.data);

  // Ready comes from registered occupancy only, so a pop never frees a slot in the same cycle.
  assign push_s = in_if.valid & in_if.ready & in_info_s.r_valid & ~flush;
  assign pop_s  = out_if.valid & out_if.ready & ~flush;

  // Next occupancy from the push/pop pair.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + ONE_C;
      2'b01:   count_next_s = count_r - ONE_C;
      default: count_next_s = count_r;
    endcase
  end

  // Pointer, occupancy and handshake-flag state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      count_r     <= ZERO_C;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else if (flush) begin
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      count_r     <= ZERO_C;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PONE_C;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PONE_C;
      end
      count_r     <= count_next_s;
      in_ready_r  <= (count_next_s != FULL_C);
      out_valid_r <= (count_next_s != ZERO_C);
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= in_info_s;
    end
  end

endmodule

// File: tb/tb_fu_wb_fifo.sv
// Directed bench for fu_wb_fifo: order, full, drop, push/pop wrap, flush, async reset.
module tb_fu_wb_fifo;
  import fu_wb_fifo_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  cdb_info_t        in_data;
  logic             out_valid;
  logic             out_ready;
  cdb_info_t        out_data;
  logic [CNT_W-1:0] count;

  int n_tests;
  int n_fail;

  fu_wb_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input int rob, input logic rv);
    in_valid        = v;
    in_data         = '0;
    in_data.rob_id  = 6'(rob);
    in_data.r_valid = rv;
    in_data.wdata   = 32'(rob * 3 + 1);
  endtask

  task automatic push_one(input int rob);
    set_in(1'b1, rob, 1'b1);
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    set_in(1'b0, 0, 1'b0);
    #12;
    chk_eq("rst_count", 32'(count), 32'd0);
    chk_eq("rst_out_valid", 32'(out_valid), 32'd0);
    chk_eq("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;

    // Basic order
    push_one(5); push_one(6); push_one(7);
    chk_eq("ord_count", 32'(count), 32'd3);
    chk_eq("ord_in_ready", 32'(in_ready), 32'd1);
    chk_eq("ord_head0", 32'(out_data.rob_id), 32'd5);
    chk_eq("ord_wdata0", out_data.wdata, 32'd16);
    out_ready = 1'b1;
    step();
    chk_eq("ord_head1", 32'(out_data.rob_id), 32'd6);
    step();
    chk_eq("ord_head2", 32'(out_data.rob_id), 32'd7);
    step();
    chk_eq("ord_empty_valid", 32'(out_valid), 32'd0);
    chk_eq("ord_empty_count", 32'(count), 32'd0);
    out_ready = 1'b0;

    // Full
    push_one(10); push_one(11); push_one(12); push_one(13);
    chk_eq("full_count", 32'(count), 32'd4);
    chk_eq("full_in_ready", 32'(in_ready), 32'd0);
    set_in(1'b1, 14, 1'b1);
    step();
    chk_eq("full_held_count", 32'(count), 32'd4);
    chk_eq("full_held_head", 32'(out_data.rob_id), 32'd10);
    out_ready = 1'b1;
    step();
    chk_eq("full_pop_count", 32'(count), 32'd3);
    chk_eq("full_pop_ready", 32'(in_ready), 32'd1);
    chk_eq("full_pop_head", 32'(out_data.rob_id), 32'd11);
    step();
    in_valid = 1'b0;
    chk_eq("full_5th_count", 32'(count), 32'd3);
    chk_eq("full_h12", 32'(out_data.rob_id), 32'd12);
    step();
    chk_eq("full_h13", 32'(out_data.rob_id), 32'd13);
    step();
    chk_eq("full_h14", 32'(out_data.rob_id), 32'd14);
    step();
    chk_eq("full_drained", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Drop
    set_in(1'b1, 9, 1'b0);
    step();
    set_in(1'b1, 10, 1'b1);
    step();
    in_valid = 1'b0;
    chk_eq("drop_count", 32'(count), 32'd1);
    chk_eq("drop_head", 32'(out_data.rob_id), 32'd10);
    out_ready = 1'b1;
    step();
    chk_eq("drop_empty", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Simultaneous push/pop across pointer wrap
    push_one(1); push_one(2);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_in(1'b1, 20 + i, 1'b1);
      step();
      chk_eq("pp_count", 32'(count), 32'd2);
      chk_eq("pp_head", 32'(out_data.rob_id), (i == 0) ? 32'd2 : 32'(20 + i - 1));
    end
    in_valid = 1'b0;
    step();
    chk_eq("pp_tail", 32'(out_data.rob_id), 32'd27);
    step();
    chk_eq("pp_empty", 32'(count), 32'd0);
    out_ready = 1'b0;

    // Flush
    push_one(30); push_one(31); push_one(32);
    chk_eq("fl_pre_count", 32'(count), 32'd3);
    set_in(1'b1, 33, 1'b1);
    flush = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk_eq("fl_count", 32'(count), 32'd0);
    chk_eq("fl_out_valid", 32'(out_valid), 32'd0);
    chk_eq("fl_in_ready", 32'(in_ready), 32'd1);
    push_one(34);
    chk_eq("fl_after_count", 32'(count), 32'd1);
    chk_eq("fl_after_head", 32'(out_data.rob_id), 32'd34);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Asynchronous reset between edges
    push_one(40); push_one(41);
    chk_eq("ar_pre_count", 32'(count), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    chk_eq("ar_count", 32'(count), 32'd0);
    chk_eq("ar_out_valid", 32'(out_valid), 32'd0);
    chk_eq("ar_in_ready", 32'(in_ready), 32'd1);
    #1;
    rst = 1'b0;
    push_one(42);
    chk_eq("ar_after_count", 32'(count), 32'd1);
    chk_eq("ar_after_head", 32'(out_data.rob_id), 32'd42);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
